// File: rtl/pipe_ram_sched_if.sv
// Signals between the pipeline control logic and the base-SRAM scheduler.
// The master side drives the requests and the slave side answers with the grant, done and stall signals.
interface pipe_ram_sched_if;
    logic       stallreq_id;
    logic       stallreq_ex;
    logic       if_req;
    logic       mem_req;
    logic       ram_ce;
    logic       ram_sel;
    logic       if_done;
    logic       mem_done;
    logic [5:0] stall;

    modport master (
        output stallreq_id, stallreq_ex, if_req, mem_req,
        input  ram_ce, ram_sel, if_done, mem_done, stall
    );

    modport slave (
        input  stallreq_id, stallreq_ex, if_req, mem_req,
        output ram_ce, ram_sel, if_done, mem_done, stall
    );
endinterface

// File: rtl/pipe_ram_sched.sv
// Round-robin arbiter for the shared base SRAM between IF and MEM.
// It also folds every stall source into the 6-bit pipeline stall vector.
module pipe_ram_sched #(
    parameter int ACC_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipe_ram_sched_if.slave   bus_s,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_ACC  = 2'd1,
        MEM_ACC = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYCLES - 1);

    if (ACC_CYCLES < 1 || ACC_CYCLES > 15 || ACC_CYCLES > (1 << CNT_W)) begin : g_bad_acc
        $error("ACC_CYCLES out of range for pipe_ram_sched");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_mem_q, last_mem_d;
    logic             if_done, mem_done;
    logic             sr_if, sr_mem;
    logic [5:0]       stall_vec;

    // Handshake: a requester raises if_req/mem_req and holds it high until the
    // matching done pulse; done marks the final access cycle, and dropping the
    // request early aborts the access with no done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_mem_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_mem_q <= last_mem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_mem_d = last_mem_q;
        case (state_q)
            IDLE: begin
                // On a tie, the side that did not win last time gets the grant.
                if (bus_s.mem_req && (!bus_s.if_req || !last_mem_q)) begin
                    state_d    = MEM_ACC;
                    cnt_d      = CNT_LOAD;
                    last_mem_d = 1'b1;
                end else if (bus_s.if_req) begin
                    state_d    = IF_ACC;
                    cnt_d      = CNT_LOAD;
                    last_mem_d = 1'b0;
                end
            end
            IF_ACC: begin
                if (!bus_s.if_req || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MEM_ACC: begin
                if (!bus_s.mem_req || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign if_done  = (state_q == IF_ACC)  && (cnt_q == '0) && bus_s.if_req;
    assign mem_done = (state_q == MEM_ACC) && (cnt_q == '0) && bus_s.mem_req;
    assign sr_mem   = bus_s.mem_req & ~mem_done;
    assign sr_if    = bus_s.if_req & ~if_done;

    always_comb begin
        stall_vec = 6'b000000;
        if (sr_mem) begin
            stall_vec = 6'b011111;
        end else if (bus_s.stallreq_ex) begin
            stall_vec = 6'b001111;
        end else if (bus_s.stallreq_id) begin
            stall_vec = 6'b000111;
        end else if (sr_if) begin
            stall_vec = 6'b000011;
        end
    end

    assign bus_s.ram_ce   = (state_q != IDLE);
    assign bus_s.ram_sel  = (state_q == MEM_ACC);
    assign bus_s.if_done  = if_done;
    assign bus_s.mem_done = mem_done;
    // Requests are raw inputs, so the vector is forced quiet while reset is held.
    assign bus_s.stall    = rst ? stall_vec : 6'b000000;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pipe_ram_sched.sv
// Bench for pipe_ram_sched: directed scenarios plus random requesters,
// all compared against a transaction-level model of the scheduler.
module tb_pipe_ram_sched;

    localparam int ACC = 2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    pipe_ram_sched_if bus ();

    pipe_ram_sched #(.ACC_CYCLES(ACC), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_s       (bus.slave),
        .dbg_state_o (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the SRAM, which cycle granted it, and who won last.
    int   own;        // 0 = free, 1 = IF, 2 = MEM
    int   grant_cyc;
    int   cyc;
    bit   last_mem;
    logic exp_if_done, exp_mem_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        own          = 0;
        grant_cyc    = 0;
        cyc          = 0;
        last_mem     = 1'b0;
        exp_if_done  = 1'b0;
        exp_mem_done = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ce"},    8'(bus.ram_ce),   8'd0);
        check_eq({tag, "_ifd"},   8'(bus.if_done),  8'd0);
        check_eq({tag, "_memd"},  8'(bus.mem_done), 8'd0);
        check_eq({tag, "_stall"}, 8'(bus.stall),    8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b0;
        bus.if_req      = 1'b0;
        bus.mem_req     = 1'b0;
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        #1;
        check_quiet("reset");
        check_eq("reset_sel", 8'(bus.ram_sel), 8'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive, let it settle, compare against the model, then advance the model.
    task automatic step(input logic i_if, input logic i_mem, input logic i_id, input logic i_ex);
        int         el;
        logic       own_req;
        logic       e_ce, e_sel;
        logic [5:0] e_stall;
        @(negedge clk);
        bus.if_req      = i_if;
        bus.mem_req     = i_mem;
        bus.stallreq_id = i_id;
        bus.stallreq_ex = i_ex;
        #1;
        el           = cyc - grant_cyc;
        own_req      = (own == 1) ? i_if : (own == 2) ? i_mem : 1'b0;
        e_ce         = (own != 0);
        e_sel        = (own == 2);
        exp_if_done  = (own == 1) && (el == ACC) && i_if;
        exp_mem_done = (own == 2) && (el == ACC) && i_mem;
        if (i_mem && !exp_mem_done)     e_stall = 6'b011111;
        else if (i_ex)                  e_stall = 6'b001111;
        else if (i_id)                  e_stall = 6'b000111;
        else if (i_if && !exp_if_done)  e_stall = 6'b000011;
        else                            e_stall = 6'b000000;
        check_eq("ram_ce",   8'(bus.ram_ce),   8'(e_ce));
        check_eq("ram_sel",  8'(bus.ram_sel),  8'(e_sel));
        check_eq("if_done",  8'(bus.if_done),  8'(exp_if_done));
        check_eq("mem_done", 8'(bus.mem_done), 8'(exp_mem_done));
        check_eq("stall",    8'(bus.stall),    8'(e_stall));
        if (own != 0) begin
            if (!own_req || el == ACC) own = 0;
        end else if (i_if || i_mem) begin
            if (i_if && i_mem) own = last_mem ? 1 : 2;
            else               own = i_mem ? 2 : 1;
            grant_cyc = cyc;
            last_mem  = (own == 2);
        end
        cyc++;
    endtask

    logic if_r, mem_r, id_r, ex_r;

    initial begin
        rst             = 1'b0;
        bus.if_req      = 1'b0;
        bus.mem_req     = 1'b0;
        bus.stallreq_id = 1'b0;
        bus.stallreq_ex = 1'b0;
        model_reset();

        // Idle after reset: nothing moves.
        do_reset();
        repeat (6) step(0, 0, 0, 0);
        check_quiet("idle");

        // Single IF access: grant at cycle 0, done at cycle ACC.
        do_reset();
        step(1, 0, 0, 0);
        check_eq("tp_if_c0_stall", 8'(bus.stall), 8'b000011);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_if_done", 8'(bus.if_done), 8'd1);
        check_eq("tp_if_c2_stall", 8'(bus.stall), 8'b000000);
        step(0, 0, 0, 0);

        // Both requesters from reset: MEM wins first, IF after one idle cycle.
        do_reset();
        step(1, 1, 0, 0);
        check_eq("tp_both_stall", 8'(bus.stall), 8'b011111);
        step(1, 1, 0, 0);
        check_eq("tp_both_sel_mem", 8'(bus.ram_sel), 8'd1);
        step(1, 1, 0, 0);
        check_eq("tp_both_memd", 8'(bus.mem_done), 8'd1);
        step(1, 0, 0, 0);
        check_eq("tp_both_gap", 8'(bus.ram_ce), 8'd0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_both_ifd", 8'(bus.if_done), 8'd1);
        step(0, 0, 0, 0);

        // MEM access with an EX stall underneath.
        do_reset();
        step(0, 1, 0, 1);
        check_eq("tp_ex_mem_stall", 8'(bus.stall), 8'b011111);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        check_eq("tp_ex_after_done", 8'(bus.stall), 8'b001111);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        check_eq("tp_id_stall", 8'(bus.stall), 8'b000111);

        // MEM aborted in its first access cycle; the pending IF then gets the SRAM.
        do_reset();
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_abort_memd", 8'(bus.mem_done), 8'd0);
        step(1, 0, 0, 0);
        check_eq("tp_abort_idle", 8'(bus.ram_ce), 8'd0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_abort_ifd", 8'(bus.if_done), 8'd1);
        step(0, 0, 0, 0);

        // Reset in the middle of an IF access, then a fresh full-latency IF access.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        check_quiet("mid_rst");
        model_reset();
        @(negedge clk);
        bus.if_req = 1'b0;
        rst        = 1'b1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("tp_rst_early", 8'(bus.if_done), 8'd0);
        step(1, 0, 0, 0);
        check_eq("tp_rst_ifd", 8'(bus.if_done), 8'd1);
        step(0, 0, 0, 0);

        // Random requesters that hold their request until done, with occasional aborts.
        do_reset();
        if_r  = 1'b0;
        mem_r = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!if_r)                                     if_r = ($urandom_range(0, 2) == 0);
            else if (exp_if_done)                          if_r = 1'b0;
            else if (own == 1 && $urandom_range(0, 15) == 0) if_r = 1'b0;
            if (!mem_r)                                    mem_r = ($urandom_range(0, 3) == 0);
            else if (exp_mem_done)                         mem_r = 1'b0;
            else if (own == 2 && $urandom_range(0, 15) == 0) mem_r = 1'b0;
            id_r = ($urandom_range(0, 5) == 0);
            ex_r = ($urandom_range(0, 6) == 0);
            step(if_r, mem_r, id_r, ex_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
